// File: rtl/note_source_arbiter.sv
// Shares the tone generator between live keys and NUM_SONGS song players; `NOTE_ARB_PLAYLIST_EN adds song_done auto-advance.
// Latency: key_on/key are registered, one cycle behind the selected source; song_rst decodes combinationally from state.
// Backpressure: none; live input preempts auto-play at once and every unselected player is held in reset.
module note_source_arbiter #(
    parameter int NUM_SONGS        = 4,
    parameter int SEL_W            = 2,
    parameter int GAP_CYCLES       = 5000000,
    parameter int LIVE_HOLD_CYCLES = 200000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   live_on,
    input  logic [3:0]             live_key,
    input  logic                   auto_en,
    input  logic [SEL_W-1:0]       song_sel,
    input  logic [NUM_SONGS-1:0]   song_on,
    input  logic [4*NUM_SONGS-1:0] song_key,
`ifdef NOTE_ARB_PLAYLIST_EN
    input  logic [NUM_SONGS-1:0]   song_done,
`endif
    output logic [NUM_SONGS-1:0]   song_rst,
    output logic                   key_on,
    output logic [3:0]             key,
    output logic [1:0]             state_o,
    output logic [SEL_W-1:0]       active_song
);

    localparam int CNT_MAX = (GAP_CYCLES > LIVE_HOLD_CYCLES) ? GAP_CYCLES : LIVE_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LIVE_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LIVE = 2'd1,
        S_GAP  = 2'd2,
        S_AUTO = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic             key_on_q, key_on_d;
    logic [3:0]       key_q, key_d;

    logic [SEL_W-1:0] sel_clamped;
    logic [SEL_W-1:0] pick;
    logic             reselect;
    logic             sel_on;
    logic [3:0]       sel_key;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Out-of-range selections fall back to song 0.
    assign sel_clamped = (32'(song_sel) < 32'(NUM_SONGS)) ? song_sel : '0;

`ifdef NOTE_ARB_PLAYLIST_EN
    logic [SEL_W-1:0] sel_prev_q;
    logic [SEL_W-1:0] target_q, target_d, target_upd;
    logic [SEL_W-1:0] next_song;
    logic             sel_chg;
    logic             done_now;

    // song_sel only steers the playlist when the switch itself moves.
    assign sel_chg    = (song_sel != sel_prev_q);
    assign target_upd = sel_chg ? sel_clamped : target_q;
    assign pick       = target_upd;
    assign reselect   = sel_chg && (sel_clamped != active_q);
    assign next_song  = (active_q == SEL_W'(NUM_SONGS - 1)) ? '0 : active_q + 1'b1;
`else
    assign pick       = sel_clamped;
    assign reselect   = (sel_clamped != active_q);
`endif

    always_comb begin
        sel_on   = 1'b0;
        sel_key  = 4'd0;
        song_rst = '1;
`ifdef NOTE_ARB_PLAYLIST_EN
        done_now = 1'b0;
`endif
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (active_q == SEL_W'(i)) begin
                sel_on  = song_on[i];
                sel_key = song_key[4*i +: 4];
`ifdef NOTE_ARB_PLAYLIST_EN
                done_now = song_done[i];
`endif
                if (state_q == S_AUTO) begin
                    song_rst[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = '0;
        active_d   = active_q;
        key_on_d   = 1'b0;
        key_d      = key_q;
`ifdef NOTE_ARB_PLAYLIST_EN
        target_d   = target_upd;
`endif
        case (state_q)
            S_IDLE: begin
                if (live_on) begin
                    state_d = S_LIVE;
                end else if (auto_en) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            S_LIVE: begin
                key_on_d = live_on;
                key_d    = live_key;
                if (live_on) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = auto_en ? S_GAP : S_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end
            S_GAP: begin
                if (live_on) begin
                    state_d = S_LIVE;
                end else if (!auto_en) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d  = S_AUTO;
                    active_d = pick;
                end else begin
                    gap_cnt_d = sat_inc(gap_cnt_q);
                end
            end
            default: begin
                // Any exit from AUTO silences the output on the following cycle.
                if (live_on) begin
                    state_d = S_LIVE;
                end else if (!auto_en) begin
                    state_d = S_IDLE;
                end else if (reselect) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
`ifdef NOTE_ARB_PLAYLIST_EN
                end else if (done_now) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                    target_d  = next_song;
`endif
                end else begin
                    key_on_d = sel_on;
                    key_d    = sel_key;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= '0;
            hold_cnt_q <= '0;
            active_q   <= '0;
            key_on_q   <= 1'b0;
            key_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            active_q   <= active_d;
            key_on_q   <= key_on_d;
            key_q      <= key_d;
        end
    end

`ifdef NOTE_ARB_PLAYLIST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_prev_q <= '0;
            target_q   <= '0;
        end else begin
            sel_prev_q <= song_sel;
            target_q   <= target_d;
        end
    end
`endif

    assign key_on      = key_on_q;
    assign key         = key_q;
    assign state_o     = state_q;
    assign active_song = active_q;

endmodule

// File: tb/tb_note_source_arbiter.sv
// Randomized scoreboard bench for note_source_arbiter: a 4-song and a 3-song instance share stimulus,
// each checked every cycle against a rule-level reference model.
`timescale 1ns/1ps
module tb_note_source_arbiter;

    localparam int GAP  = 4;
    localparam int HOLD = 10;
    localparam int M_IDLE = 0, M_LIVE = 1, M_GAP = 2, M_AUTO = 3;

    typedef struct {
        int         mode;
        int         quiet;
        int         gap_left;
        int         active;
        int         target;
        int         prev_sel;
        logic       kon;
        logic [3:0] key;
    } mdl_t;

    typedef struct {
        logic        live_on;
        logic [3:0]  live_key;
        logic        auto_en;
        int          sel;
        logic [3:0]  son;
        logic [15:0] skey;
        logic [3:0]  sdone;
    } stim_t;

    typedef struct {
        int         st;
        int         act;
        logic       kon;
        logic [3:0] key;
        logic [3:0] srst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        live_on;
    logic [3:0]  live_key;
    logic        auto_en;
    logic [1:0]  song_sel;
    logic [3:0]  song_on;
    logic [15:0] song_key;
`ifdef NOTE_ARB_PLAYLIST_EN
    logic [3:0]  song_done;
`endif

    logic [3:0] d4_rst;
    logic       d4_kon;
    logic [3:0] d4_key;
    logic [1:0] d4_st;
    logic [1:0] d4_act;
    logic [2:0] d3_rst;
    logic       d3_kon;
    logic [3:0] d3_key;
    logic [1:0] d3_st;
    logic [1:0] d3_act;

    int checks   = 0;
    int failures = 0;

    mdl_t  m4, m3;
    stim_t cur;
    exp_t  q4[$];
    exp_t  q3[$];

    note_source_arbiter #(.NUM_SONGS(4), .SEL_W(2), .GAP_CYCLES(GAP), .LIVE_HOLD_CYCLES(HOLD)) u_dut4 (
        .clk(clk), .rst(rst), .live_on(live_on), .live_key(live_key), .auto_en(auto_en),
        .song_sel(song_sel), .song_on(song_on), .song_key(song_key),
`ifdef NOTE_ARB_PLAYLIST_EN
        .song_done(song_done),
`endif
        .song_rst(d4_rst), .key_on(d4_kon), .key(d4_key), .state_o(d4_st), .active_song(d4_act)
    );

    note_source_arbiter #(.NUM_SONGS(3), .SEL_W(2), .GAP_CYCLES(GAP), .LIVE_HOLD_CYCLES(HOLD)) u_dut3 (
        .clk(clk), .rst(rst), .live_on(live_on), .live_key(live_key), .auto_en(auto_en),
        .song_sel(song_sel), .song_on(song_on[2:0]), .song_key(song_key[11:0]),
`ifdef NOTE_ARB_PLAYLIST_EN
        .song_done(song_done[2:0]),
`endif
        .song_rst(d3_rst), .key_on(d3_kon), .key(d3_key), .state_o(d3_st), .active_song(d3_act)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic mdl_t minit();
        mdl_t m;
        m.mode = M_IDLE; m.quiet = 0; m.gap_left = 0; m.active = 0;
        m.target = 0; m.prev_sel = 0; m.kon = 1'b0; m.key = 4'd0;
        return m;
    endfunction

    // One clock of the behavioural rules for an ns-song arbiter.
    function automatic mdl_t mstep(mdl_t m, stim_t s, int ns);
        mdl_t n;
        int   want;
        bit   chg;
        n     = m;
        n.kon = 1'b0;
        want  = (s.sel < ns) ? s.sel : 0;
        chg   = (s.sel != m.prev_sel);
        n.prev_sel = s.sel;
        if (chg) n.target = want;
        case (m.mode)
            M_IDLE: begin
                if (s.live_on) begin n.mode = M_LIVE; n.quiet = 0; end
                else if (s.auto_en) begin n.mode = M_GAP; n.gap_left = GAP; end
            end
            M_LIVE: begin
                n.kon = s.live_on;
                n.key = s.live_key;
                if (s.live_on) n.quiet = 0;
                else begin
                    n.quiet = m.quiet + 1;
                    if (n.quiet == HOLD) begin
                        n.mode = s.auto_en ? M_GAP : M_IDLE;
                        n.gap_left = GAP;
                    end
                end
            end
            M_GAP: begin
                if (s.live_on) begin n.mode = M_LIVE; n.quiet = 0; end
                else if (!s.auto_en) n.mode = M_IDLE;
                else begin
                    n.gap_left = m.gap_left - 1;
                    if (n.gap_left == 0) begin
                        n.mode = M_AUTO;
`ifdef NOTE_ARB_PLAYLIST_EN
                        n.active = n.target;
`else
                        n.active = want;
`endif
                    end
                end
            end
            default: begin
                if (s.live_on) begin n.mode = M_LIVE; n.quiet = 0; end
                else if (!s.auto_en) n.mode = M_IDLE;
`ifdef NOTE_ARB_PLAYLIST_EN
                else if (chg && want != m.active) begin n.mode = M_GAP; n.gap_left = GAP; end
                else if (s.sdone[m.active]) begin
                    n.mode = M_GAP; n.gap_left = GAP; n.target = (m.active + 1) % ns;
                end
`else
                else if (want != m.active) begin n.mode = M_GAP; n.gap_left = GAP; end
`endif
                else begin
                    n.kon = s.son[m.active];
                    n.key = s.skey[4*m.active +: 4];
                end
            end
        endcase
        return n;
    endfunction

    function automatic exp_t exp_of(mdl_t m, int ns);
        exp_t       e;
        logic [3:0] mask;
        mask   = (ns == 3) ? 4'b0111 : 4'b1111;
        e.st   = m.mode;
        e.act  = m.active;
        e.kon  = m.kon;
        e.key  = m.key;
        e.srst = (m.mode == M_AUTO) ? (mask & ~(4'b0001 << m.active)) : mask;
        return e;
    endfunction

    task automatic step(input stim_t s);
        @(negedge clk);
        live_on  = s.live_on;
        live_key = s.live_key;
        auto_en  = s.auto_en;
        song_sel = 2'(s.sel);
        song_on  = s.son;
        song_key = s.skey;
`ifdef NOTE_ARB_PLAYLIST_EN
        song_done = s.sdone;
`endif
        m4 = mstep(m4, s, 4);
        q4.push_back(exp_of(m4, 4));
        m3 = mstep(m3, s, 3);
        q3.push_back(exp_of(m3, 3));
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: every cycle the DUTs present an output, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("d4_state", int'(d4_st), e.st);
                chk("d4_active", int'(d4_act), e.act);
                chk("d4_key_on", int'(d4_kon), int'(e.kon));
                chk("d4_key", int'(d4_key), int'(e.key));
                chk("d4_song_rst", int'(d4_rst), int'(e.srst));
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("d3_state", int'(d3_st), e.st);
                chk("d3_active", int'(d3_act), e.act);
                chk("d3_key_on", int'(d3_kon), int'(e.kon));
                chk("d3_key", int'(d3_key), int'(e.key));
                chk("d3_song_rst", int'(d3_rst), int'(e.srst));
            end
        end
    end

    initial begin
        rst = 1'b1;
        live_on = 1'b0; live_key = 4'd0; auto_en = 1'b0; song_sel = 2'd0;
        song_on = 4'd0; song_key = 16'd0;
`ifdef NOTE_ARB_PLAYLIST_EN
        song_done = 4'd0;
`endif
        cur = '{live_on: 1'b0, live_key: 4'd0, auto_en: 1'b0, sel: 0, son: 4'd0, skey: 16'd0, sdone: 4'd0};
        m4 = minit();
        m3 = minit();

        repeat (2) @(posedge clk);
        #3;
        chk("rst_key_on", int'(d4_kon), 0);
        chk("rst_key", int'(d4_key), 0);
        chk("rst_song_rst", int'(d4_rst), 15);
        chk("rst_state", int'(d4_st), 0);
        chk("rst_active", int'(d4_act), 0);
        chk("rst_song_rst3", int'(d3_rst), 7);
        #1 rst = 1'b0;

        // Auto-play start on song 2 after a 4-cycle gap.
        cur.auto_en = 1'b1; cur.sel = 2; cur.son = 4'b0100; cur.skey = 16'h0700;
        step(cur);
        settle();
        chk("t1_gap_state", int'(d4_st), M_GAP);
        repeat (4) step(cur);
        settle();
        chk("t1_auto_state", int'(d4_st), M_AUTO);
        chk("t1_active", int'(d4_act), 2);
        chk("t1_song_rst", int'(d4_rst), 4'b1011);
        step(cur);
        settle();
        chk("t1_key_on", int'(d4_kon), 1);
        chk("t1_key", int'(d4_key), 7);

        // Live preemption, then 10-cycle hold before the gap.
        cur.live_on = 1'b1; cur.live_key = 4'd5;
        step(cur);
        settle();
        chk("t2_live_state", int'(d4_st), M_LIVE);
        chk("t2_enter_key_on", int'(d4_kon), 0);
        chk("t2_song_rst", int'(d4_rst), 15);
        step(cur);
        settle();
        chk("t2_live_key_on", int'(d4_kon), 1);
        chk("t2_live_key", int'(d4_key), 5);
        cur.live_on = 1'b0;
        repeat (9) step(cur);
        settle();
        chk("t2_still_live", int'(d4_st), M_LIVE);
        step(cur);
        settle();
        chk("t2_hold_gap", int'(d4_st), M_GAP);
        repeat (4) step(cur);
        settle();
        chk("t2_back_auto", int'(d4_st), M_AUTO);

        // Reselect song 1: restart through a gap.
        cur.sel = 1; cur.son = 4'b0010; cur.skey = 16'h0030;
        step(cur);
        settle();
        chk("t3_gap_state", int'(d4_st), M_GAP);
        chk("t3_gap_key_on", int'(d4_kon), 0);
        repeat (4) step(cur);
        settle();
        chk("t3_active", int'(d4_act), 1);
        chk("t3_song_rst", int'(d4_rst), 4'b1101);

        // Live wins over a simultaneous reselect, then auto_en off returns to idle.
        cur.sel = 3; cur.live_on = 1'b1; cur.live_key = 4'd9;
        step(cur);
        settle();
        chk("t4_live_wins", int'(d4_st), M_LIVE);
        cur.live_on = 1'b0; cur.auto_en = 1'b0;
        repeat (10) step(cur);
        settle();
        chk("t4_idle", int'(d4_st), M_IDLE);
        chk("t4_idle_key_on", int'(d4_kon), 0);

        // Out-of-range select on the 3-song instance clamps to 0; then asynchronous reset mid-AUTO.
        cur.auto_en = 1'b1; cur.son = 4'b1001; cur.skey = 16'hA00B;
        repeat (5) step(cur);
        step(cur);
        @(posedge clk);
        #3;
        chk("t5_d3_active", int'(d3_act), 0);
        chk("t5_d3_song_rst", int'(d3_rst), 3'b110);
        chk("t5_d3_key", int'(d3_key), 4'hB);
        chk("t5_d4_active", int'(d4_act), 3);
        chk("t5_d4_key", int'(d4_key), 4'hA);
        chk("t5_pre_rst_key_on", int'(d4_kon), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_arst_song_rst", int'(d4_rst), 15);
        chk("t5_arst_key_on", int'(d4_kon), 0);
        chk("t5_arst_state", int'(d4_st), 0);
        chk("t5_arst_song_rst3", int'(d3_rst), 7);
        chk("t5_arst_key_on3", int'(d3_kon), 0);
        #1 rst = 1'b0;
        m4 = minit();
        m3 = minit();

`ifdef NOTE_ARB_PLAYLIST_EN
        // Playlist advance 2 -> 3 -> 0 on song_done pulses.
        cur.sel = 2; cur.son = 4'd0; cur.sdone = 4'd0;
        repeat (5) step(cur);
        cur.sdone = 4'b0100;
        step(cur);
        cur.sdone = 4'd0;
        settle();
        chk("t6_done_gap", int'(d4_st), M_GAP);
        repeat (4) step(cur);
        settle();
        chk("t6_next_song", int'(d4_act), 3);
        cur.sdone = 4'b1000;
        step(cur);
        cur.sdone = 4'd0;
        repeat (4) step(cur);
        settle();
        chk("t6_wrap_song", int'(d4_act), 0);
        chk("t6_wrap_state", int'(d4_st), M_AUTO);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if (cur.live_on) begin
                if ($urandom_range(0, 5) == 0) cur.live_on = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                cur.live_on = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) cur.auto_en = ~cur.auto_en;
            if ($urandom_range(0, 24) == 0) cur.sel = int'($urandom_range(0, 3));
            cur.live_key = 4'($urandom);
            cur.son      = 4'($urandom);
            cur.skey     = 16'($urandom);
            cur.sdone    = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            step(cur);
        end

        @(posedge clk);
        #5;
        chk("queues_drained", q4.size() + q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_source_arbiter.md
Name: note_source_arbiter

Overview:
Shares the piano tone generator between the live keyboard and NUM_SONGS auto-play song players.
- Live input always preempts auto-play.
- Selects and sequences one song player at a time; holds all others in reset.
- Inserts a silent gap before any auto-play (re)start.
- Drives the single key_on/key pair consumed by the tone/buzzer block.

Parameters:
NUM_SONGS, 4, number of song-player inputs (2..8).
SEL_W, 2, width of song_sel; must satisfy 2**SEL_W >= NUM_SONGS.
GAP_CYCLES, 5000000, silent cycles before auto-play (re)starts (50 ms at 100 MHz); >= 1.
LIVE_HOLD_CYCLES, 200000000, consecutive cycles of live_on low before leaving LIVE (2 s); >= 1.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
live_on  input  1  keyboard key pressed
live_key  input  4  keyboard note code
auto_en  input  1  auto-play enable (switch)
song_sel  input  SEL_W  requested song index
song_on  input  NUM_SONGS  key_on from each song player
song_key  input  4*NUM_SONGS  key from each player; player n occupies bits [4n+3:4n]
song_rst  output  NUM_SONGS  active-high reset to each song player
key_on  output  1  note active to tone generator
key  output  4  note code to tone generator
state_o  output  2  current state: 0 IDLE, 1 LIVE, 2 GAP, 3 AUTO
active_song  output  SEL_W  index of the song currently granted

Behaviour:
Reset values:
- state IDLE; key_on 0; key 0.
- song_rst all ones; active_song 0.
- gap and hold counters 0.

Outputs:
- key_on and key are registered, with exactly 1-cycle latency from the selected source.

IDLE:
- key_on 0; all song_rst 1.
- live_on=1 -> LIVE.
- Else auto_en=1 -> GAP, gap counter cleared.

LIVE:
- key_on<=live_on, key<=live_key; all song_rst 1.
- Hold counter clears whenever live_on=1 and increments while live_on=0.
- When the counter reaches LIVE_HOLD_CYCLES-1 with live_on=0: go to GAP if auto_en=1, else IDLE.

GAP:
- key_on 0; key holds its last value; all song_rst 1.
- Priority order:
  - live_on=1 -> LIVE (same cycle, overriding everything else).
  - auto_en=0 -> IDLE.
  - Counter reaches GAP_CYCLES-1 -> AUTO. active_song latches song_sel; a song_sel >= NUM_SONGS latches 0.

AUTO:
- song_rst[active_song]=0, all other bits 1.
- key_on<=song_on[active_song], key<=song_key slice of active_song.
- Priority order:
  1. live_on=1 -> LIVE. key_on is 0 on the next cycle; live data appears one cycle after entering LIVE.
  2. auto_en=0 -> IDLE.
  3. song_sel differs from active_song (after clamping) -> GAP. The new song restarts from note 0 because its player is held in reset during the gap.

Simultaneous events:
- Live preempts song_sel change and auto_en drop.
- auto_en drop preempts song_sel change.

Counters:
- Unsigned; width $clog2(max(GAP_CYCLES, LIVE_HOLD_CYCLES)+1).
- Counters saturate and never wrap.

Reset mid-operation:
- rst immediately forces the reset values above, including song_rst all ones and key_on 0 asynchronously.

Optional Feature:
NOTE_ARB_PLAYLIST_EN
- Defined:
  - Adds input song_done [NUM_SONGS], one single-cycle pulse per player at end of song.
  - In AUTO, song_done[active_song]=1 -> GAP, then AUTO with active_song+1, wrapping NUM_SONGS-1 -> 0.
  - The song_sel input is re-sampled only when song_sel itself changes; a change takes priority over song_done in the same cycle.
- Undefined: no song_done port; a song plays until preempted or reselected.

Test Plan:
Bench parameters GAP_CYCLES=4, LIVE_HOLD_CYCLES=10.
1. Reset -> key_on=0, key=0, song_rst=4'b1111, state_o=0. Then auto_en=1, song_sel=2 -> state GAP for 4 cycles, then AUTO, song_rst=4'b1011, active_song=2. song_on[2]=1, key slice=7 -> key_on=1, key=7 one cycle later.
2. In AUTO, live_on=1, live_key=5 -> next cycle state LIVE, key_on=0, song_rst=4'b1111; following cycle key_on=1, key=5. Release live_on -> exactly 10 cycles later state GAP (auto_en=1), then AUTO 4 cycles after that.
3. In AUTO on song 2, change song_sel to 1 -> GAP (key_on=0, 4 cycles), then AUTO with active_song=1, song_rst=4'b1101.
4. Same cycle: song_sel change and live_on=1 -> LIVE. Then auto_en=0 and release for 10 cycles -> IDLE, key_on=0.
5. Out-of-range/boundary: with NUM_SONGS=3, song_sel=3 -> active_song=0. Assert rst mid-AUTO -> song_rst=all ones and key_on=0 without waiting for a clock edge.
6. (NOTE_ARB_PLAYLIST_EN) song_done[2] pulse in AUTO on song 2 of 4 -> GAP, then active_song=3. song_done[3] -> GAP, then active_song=0.
